hline_arbiter: RTL and testbench

- Shares one horizontal-span iterator between NREQ independent span producers (fill units, UI overlays, clear engine).
- Grants spans using a round-robin policy and latches the winning span's x0/x1/y.
- Drives the iterator's start and coordinates, waits for its done pulse, then returns a one-cycle ack to the owning requester.
- Sits between the render front-ends and the single span iterator feeding the framebuffer writer.

---
 rtl/hline_arbiter_if.sv | 36 +++
 rtl/hline_arbiter.sv | 114 +++++++++++
 tb/tb_hline_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hline_arbiter_if.sv
// hline_arbiter_if: bundles the requester-side span bus and the iterator-side
// line bus of the span arbiter. The master modport is the arbiter itself; the
// slave modport is its environment (requesters plus span iterator).
interface hline_arbiter_if #(
   parameter int CORDW = 10,
   parameter int NREQ  = 4
);
   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // requester side
   logic [NREQ-1:0]       req;
   logic [NREQ*CORDW-1:0] req_x0;
   logic [NREQ*CORDW-1:0] req_x1;
   logic [NREQ*CORDW-1:0] req_y;
   logic [NREQ-1:0]       ack;
   logic [IDXW-1:0]       owner;
   logic                  busy;

   // iterator side
   logic                  line_start;
   logic [CORDW-1:0]      line_x0;
   logic [CORDW-1:0]      line_x1;
   logic [CORDW-1:0]      line_y;
   logic                  line_busy;
   logic                  line_done;

   modport master (
      input  req, req_x0, req_x1, req_y, line_busy, line_done,
      output ack, owner, busy, line_start, line_x0, line_x1, line_y
   );

   modport slave (
      output req, req_x0, req_x1, req_y, line_busy, line_done,
      input  ack, owner, busy, line_start, line_x0, line_x1, line_y
   );
endinterface

// File: rtl/hline_arbiter.sv
// hline_arbiter: round-robin share of one span iterator among NREQ producers.
// Grant in IDLE, start pulse next cycle, ack one cycle after line_done (3 cycles min overhead).
// Optional macro HLINE_ARB_ORDER_EN: swap x0/x1 at grant so the iterator always counts up.
module hline_arbiter #(
   parameter int CORDW = 10,
   parameter int NREQ  = 4,
   parameter int IDXW  = $clog2(NREQ)
) (
   input  logic           clk,
   input  logic           rst,
   hline_arbiter_if.master bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_ACK   = 2'd3;

   logic [1:0]       state;
   logic [IDXW-1:0]  rr;
   logic [IDXW-1:0]  sel;
   logic             found;
   logic [IDXW:0]    cand;
   logic [CORDW-1:0] sx0;
   logic [CORDW-1:0] sx1;
   logic [CORDW-1:0] sy;
   logic [CORDW-1:0] gx0;
   logic [CORDW-1:0] gx1;

   // line_busy only qualifies line_done on the iterator side; the arbiter
   // trusts the done pulse alone, so the signal is deliberately left unused.
   wire unused_line_busy = bus.line_busy;

   // Round-robin pick: first set req bit scanning rr, rr+1, ... modulo NREQ.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr} + (IDXW+1)'(k);
         if (cand >= (IDXW+1)'(NREQ)) begin
            cand = cand - (IDXW+1)'(NREQ);
         end
         if (!found && bus.req[cand[IDXW-1:0]]) begin
            found = 1'b1;
            sel   = cand[IDXW-1:0];
         end
      end
   end

   assign sx0 = bus.req_x0[int'(sel)*CORDW +: CORDW];
   assign sx1 = bus.req_x1[int'(sel)*CORDW +: CORDW];
   assign sy  = bus.req_y [int'(sel)*CORDW +: CORDW];

   // Endpoints as handed to the iterator; optionally normalised to ascending.
   always_comb begin
      gx0 = sx0;
      gx1 = sx1;
`ifdef HLINE_ARB_ORDER_EN
      if (sx0 > sx1) begin
         gx0 = sx1;
         gx1 = sx0;
      end
`else
`endif
   end

   // Span FSM: grant, one-cycle start, wait for done, one-cycle ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         rr             <= '0;
         bus.ack        <= '0;
         bus.owner      <= '0;
         bus.busy       <= 1'b0;
         bus.line_start <= 1'b0;
         bus.line_x0    <= '0;
         bus.line_x1    <= '0;
         bus.line_y     <= '0;
      end else begin
         bus.line_start <= 1'b0;
         bus.ack        <= '0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  bus.line_x0    <= gx0;
                  bus.line_x1    <= gx1;
                  bus.line_y     <= sy;
                  bus.owner      <= sel;
                  bus.busy       <= 1'b1;
                  bus.line_start <= 1'b1;
                  state          <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.line_done) begin
                  bus.ack  <= NREQ'(1) << bus.owner;
                  bus.busy <= 1'b0;
                  state    <= S_ACK;
               end
            end
            S_ACK: begin
               rr    <= (bus.owner == IDXW'(NREQ-1)) ? '0 : bus.owner + IDXW'(1);
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_hline_arbiter.sv
// tb_hline_arbiter: directed scenarios plus randomized spans against a
// round-robin reference model; the bench plays both requesters and iterator.
module tb_hline_arbiter;
   localparam int CORDW = 10;
   localparam int NREQ  = 4;
   localparam int IDXW  = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hline_arbiter_if #(.CORDW(CORDW), .NREQ(NREQ)) bus ();

   hline_arbiter #(.CORDW(CORDW), .NREQ(NREQ), .IDXW(IDXW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passed = 0;
   int starts = 0;
   int model_rr = 0;
   logic [CORDW-1:0] dx0 [NREQ];
   logic [CORDW-1:0] dx1 [NREQ];
   logic [CORDW-1:0] dy  [NREQ];

   always @(posedge clk) if (bus.line_start === 1'b1) starts++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_data();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_x0[i*CORDW +: CORDW] = dx0[i];
         bus.req_x1[i*CORDW +: CORDW] = dx1[i];
         bus.req_y [i*CORDW +: CORDW] = dy[i];
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      model_rr = 0;
   endtask

   // Round-robin reference: lowest-numbered request after rotating the mask
   // so that the last winner's successor sits at position 0.
   function automatic int model_pick(input logic [NREQ-1:0] m);
      for (int k = 0; k < NREQ; k++) begin
         if (m[(model_rr + k) % NREQ]) return (model_rr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.line_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Iterator model: busy from start, done pulse after 'delay' extra cycles.
   // Returns positioned in the cycle after done (the ack cycle).
   task automatic finish_span(input int delay);
      bus.line_busy = 1'b1;
      tick();
      repeat (delay) tick();
      bus.line_done = 1'b1;
      tick();
      bus.line_done = 1'b0;
      bus.line_busy = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req = '0;
      bus.line_done = 1'b0;
      bus.line_busy = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         dx0[i] = '0; dx1[i] = '0; dy[i] = '0;
      end
      drive_data();
      tick();
      tick();
      checks++;
      if ({bus.busy, bus.line_start, bus.ack} !== 6'b0)
         $display("FAIL reset_ctl: busy/start/ack=%b want 000000", {bus.busy, bus.line_start, bus.ack});
      else passed++;
      checks++;
      if ({bus.owner, bus.line_x0, bus.line_x1, bus.line_y} !== '0)
         $display("FAIL reset_data: owner=%0d x0=%0d x1=%0d y=%0d want all 0",
                  bus.owner, bus.line_x0, bus.line_x1, bus.line_y);
      else passed++;
      rst = 1'b0;
      tick();
      model_rr = 0;
   endtask

   task automatic test_single();
      bit ok;
      int s0;
      dx0[0] = 10'd5; dx1[0] = 10'd9; dy[0] = 10'd3;
      drive_data();
      s0 = starts;
      bus.req = 4'b0001;
      wait_start(ok);
      checks++;
      if (!ok) $display("FAIL single_start: no line_start within bound, want one");
      else passed++;
      checks++;
      if ({bus.line_x0, bus.line_x1, bus.line_y} !== {10'd5, 10'd9, 10'd3})
         $display("FAIL single_coords: %0d/%0d/%0d want 5/9/3", bus.line_x0, bus.line_x1, bus.line_y);
      else passed++;
      checks++;
      if (bus.owner !== 2'd0 || bus.busy !== 1'b1)
         $display("FAIL single_owner: owner=%0d busy=%b want 0 1", bus.owner, bus.busy);
      else passed++;
      finish_span(4);
      checks++;
      if (bus.ack !== 4'b0001) $display("FAIL single_ack: ack=%b want 0001", bus.ack);
      else passed++;
      bus.req = '0;
      tick();
      checks++;
      if (bus.ack !== 4'b0000 || bus.busy !== 1'b0)
         $display("FAIL single_after: ack=%b busy=%b want 0000 0", bus.ack, bus.busy);
      else passed++;
      tick();
      checks++;
      if (starts - s0 != 1) $display("FAIL single_start_count: %0d starts want 1", starts - s0);
      else passed++;
      model_rr = 1;
   endtask

   task automatic test_rotation();
      bit ok;
      int exp;
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         dx0[i] = '0; dx1[i] = '0; dy[i] = '0;
      end
      drive_data();
      bus.req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         exp = model_pick(4'b1111);
         wait_start(ok);
         checks++;
         if (!ok || bus.owner !== IDXW'(exp))
            $display("FAIL rotate_owner[%0d]: started=%b owner=%0d want %0d", n, ok, bus.owner, exp);
         else passed++;
         finish_span(1);
         checks++;
         if (bus.ack !== (NREQ'(1) << exp))
            $display("FAIL rotate_ack[%0d]: ack=%b want %b", n, bus.ack, NREQ'(1) << exp);
         else passed++;
         model_rr = (exp + 1) % NREQ;
      end
      bus.req = '0;
      tick();
      tick();
   endtask

   task automatic test_hold_data();
      bit ok;
      bit bad;
      dx0[2] = 10'd10; dx1[2] = 10'd40; dy[2] = 10'd7;
      drive_data();
      bus.req = 4'b0100;
      wait_start(ok);
      checks++;
      if (!ok || bus.owner !== 2'd2)
         $display("FAIL hold_owner: started=%b owner=%0d want 2", ok, bus.owner);
      else passed++;
      bus.req_x0[2*CORDW +: CORDW] = 10'd50;
      bus.req = '0;
      bus.line_busy = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.line_x0 !== 10'd10) bad = 1'b1;
      end
      bus.line_done = 1'b1;
      tick();
      bus.line_done = 1'b0;
      bus.line_busy = 1'b0;
      checks++;
      if (bad || bus.line_x0 !== 10'd10)
         $display("FAIL hold_x0: line_x0=%0d (glitch=%b) want 10", bus.line_x0, bad);
      else passed++;
      checks++;
      if (bus.ack !== 4'b0100) $display("FAIL hold_ack: ack=%b want 0100", bus.ack);
      else passed++;
      model_rr = 3;
      dx0[2] = 10'd50;
      tick();
   endtask

   task automatic test_reset_mid();
      bit ok;
      bus.req = 4'b0010;
      wait_start(ok);
      tick();
      tick();
      checks++;
      if (!ok || bus.owner !== 2'd1 || bus.busy !== 1'b1)
         $display("FAIL rstmid_pre: started=%b owner=%0d busy=%b want 1 1 1", ok, bus.owner, bus.busy);
      else passed++;
      rst = 1'b1;
      bus.req = '0;
      #1;
      checks++;
      if ({bus.busy, bus.line_start, bus.ack, bus.owner} !== 8'b0)
         $display("FAIL rstmid_async: busy=%b start=%b ack=%b owner=%0d want all 0",
                  bus.busy, bus.line_start, bus.ack, bus.owner);
      else passed++;
      bus.line_done = 1'b1;
      tick();
      bus.line_done = 1'b0;
      rst = 1'b0;
      tick();
      checks++;
      if (bus.ack !== 4'b0000) $display("FAIL rstmid_noack: ack=%b want 0000", bus.ack);
      else passed++;
      model_rr = 0;
      bus.req = 4'b1001;
      wait_start(ok);
      checks++;
      if (!ok || bus.owner !== 2'd0)
         $display("FAIL rstmid_rr: started=%b owner=%0d want 0", ok, bus.owner);
      else passed++;
      finish_span(1);
      bus.req = '0;
      model_rr = 1;
      tick();
   endtask

   task automatic test_order();
      bit ok;
      logic [CORDW-1:0] ex0, ex1;
`ifdef HLINE_ARB_ORDER_EN
      ex0 = 10'd12; ex1 = 10'd20;
`else
      ex0 = 10'd20; ex1 = 10'd12;
`endif
      dx0[0] = 10'd20; dx1[0] = 10'd12; dy[0] = 10'd99;
      drive_data();
      bus.req = 4'b0001;
      wait_start(ok);
      checks++;
      if (!ok || bus.line_x0 !== ex0 || bus.line_x1 !== ex1)
         $display("FAIL order_x: started=%b x0=%0d x1=%0d want %0d %0d", ok, bus.line_x0, bus.line_x1, ex0, ex1);
      else passed++;
      finish_span(2);
      checks++;
      if (bus.ack !== 4'b0001) $display("FAIL order_ack: ack=%b want 0001", bus.ack);
      else passed++;
      bus.req = '0;
      model_rr = 1;
      tick();
   endtask

   task automatic test_spurious();
      bit ok;
      tick();
      bus.line_done = 1'b1;
      tick();
      bus.line_done = 1'b0;
      checks++;
      if (bus.ack !== 4'b0000 || bus.busy !== 1'b0)
         $display("FAIL spur_idle: ack=%b busy=%b want 0000 0", bus.ack, bus.busy);
      else passed++;
      tick();
      checks++;
      if (bus.line_start !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 4'b0000)
         $display("FAIL spur_idle2: start=%b busy=%b ack=%b want 0 0 0000", bus.line_start, bus.busy, bus.ack);
      else passed++;
      bus.req = 4'b0100;
      wait_start(ok);
      bus.line_done = 1'b1;
      tick();
      bus.line_done = 1'b0;
      checks++;
      if (!ok || bus.ack !== 4'b0000 || bus.busy !== 1'b1)
         $display("FAIL spur_issue: started=%b ack=%b busy=%b want 1 0000 1", ok, bus.ack, bus.busy);
      else passed++;
      finish_span(1);
      checks++;
      if (bus.ack !== 4'b0100) $display("FAIL spur_ack: ack=%b want 0100", bus.ack);
      else passed++;
      bus.req = '0;
      model_rr = 3;
      tick();
   endtask

   task automatic test_random();
      bit ok;
      int exp;
      logic [NREQ-1:0] pending, newbits;
      logic [CORDW-1:0] gx0, gx1, gy;
      pending = '0;
      for (int n = 0; n < 60; n++) begin
         newbits = NREQ'($urandom_range(0, 15)) & ~pending;
         if ((pending | newbits) == '0) newbits = NREQ'(1) << $urandom_range(0, NREQ-1);
         for (int i = 0; i < NREQ; i++) begin
            if (newbits[i]) begin
               dx0[i] = CORDW'($urandom_range(0, 1023));
               dx1[i] = CORDW'($urandom_range(1023, int'(dx0[i])));
               dy[i]  = CORDW'($urandom_range(0, 1023));
            end
         end
         drive_data();
         pending = pending | newbits;
         bus.req = pending;
         exp = model_pick(pending);
         gx0 = dx0[exp]; gx1 = dx1[exp]; gy = dy[exp];
         wait_start(ok);
         checks++;
         if (!ok || bus.owner !== IDXW'(exp) || {bus.line_x0, bus.line_x1, bus.line_y} !== {gx0, gx1, gy})
            $display("FAIL rand_grant[%0d]: started=%b owner=%0d x0=%0d x1=%0d y=%0d want %0d %0d %0d %0d",
                     n, ok, bus.owner, bus.line_x0, bus.line_x1, bus.line_y, exp, gx0, gx1, gy);
         else passed++;
         dx0[exp] = CORDW'($urandom_range(0, 1023));
         drive_data();
         finish_span($urandom_range(0, 5));
         checks++;
         if (bus.ack !== (NREQ'(1) << exp) || {bus.line_x0, bus.line_x1, bus.line_y} !== {gx0, gx1, gy})
            $display("FAIL rand_ack[%0d]: ack=%b x0=%0d want %b %0d", n, bus.ack, bus.line_x0, NREQ'(1) << exp, gx0);
         else passed++;
         pending[exp] = 1'b0;
         bus.req = pending;
         model_rr = (exp + 1) % NREQ;
      end
      bus.req = '0;
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_hold_data();
      test_reset_mid();
      test_order();
      test_spurious();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
